// File: rtl/sys_bus_arbiter.sv
// sys_bus_arbiter: round-robin arbiter that hands a single slave port to one of
// NUM_MASTERS masters per transaction (IDLE -> ACCESS -> RESP), with optional timeout.
module sys_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int W_OP_WIDTH  = 3,
  parameter int TIMEOUT     = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_request,
  input  logic [NUM_MASTERS-1:0]            m_abort,
  input  logic [NUM_MASTERS-1:0]            m_we,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  input  logic [NUM_MASTERS*W_OP_WIDTH-1:0] m_w_op,
  output logic [NUM_MASTERS-1:0]            m_grant,
  output logic [NUM_MASTERS-1:0]            m_rvalid,
  output logic                              m_err,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic                              s_request,
  output logic                              s_we,
  output logic [ADDR_WIDTH-1:0]             s_adr,
  output logic [DATA_WIDTH-1:0]             s_wdata,
  output logic [W_OP_WIDTH-1:0]             s_w_op,
  input  logic [DATA_WIDTH-1:0]             s_rdata,
  input  logic                              s_ready
);

  localparam int ID_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_MASTERS - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [ID_W-1:0]         id_reg;
  logic [ID_W-1:0]         last_id_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic                    we_reg;
  logic [ADDR_WIDTH-1:0]   adr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [W_OP_WIDTH-1:0]   w_op_reg;
  logic [DATA_WIDTH-1:0]   m_rdata_reg;
  logic                    m_err_reg;

  logic [NUM_MASTERS-1:0]  eligible;
  logic                    win_found;
  logic [ID_W-1:0]         win_id;
  logic                    timeout_hit;

  logic [ADDR_WIDTH-1:0]   adr_arr   [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]   wdata_arr [NUM_MASTERS];
  logic [W_OP_WIDTH-1:0]   w_op_arr  [NUM_MASTERS];

  assign eligible = m_request & ~m_abort;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      assign adr_arr[gi]   = m_adr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = m_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign w_op_arr[gi]  = m_w_op[gi*W_OP_WIDTH +: W_OP_WIDTH];
      assign m_grant[gi]   = (state_reg != IDLE) && (id_reg == ID_W'(gi));
      assign m_rvalid[gi]  = (state_reg == RESP) && (id_reg == ID_W'(gi));
    end
  endgenerate

  // Round-robin search starts just past the previous winner and wraps.
  always_comb begin
    logic [ID_W-1:0] cand;
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = ID_W'((int'(last_id_reg) + k) % NUM_MASTERS);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // s_ready on the final allowed cycle takes precedence over the timeout.
  assign timeout_hit = TIMEOUT_EN && (state_reg == ACCESS) && !s_ready && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (win_found) state_next = ACCESS;
      ACCESS:  if (s_ready || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_request = 1'b0;
    s_we      = 1'b0;
    s_adr     = '0;
    s_wdata   = '0;
    s_w_op    = '0;
    if (state_reg == ACCESS) begin
      s_request = 1'b1;
      s_we      = we_reg;
      s_adr     = adr_reg;
      s_wdata   = wdata_reg;
      s_w_op    = w_op_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_reg      <= '0;
      last_id_reg <= ID_LAST;
      cnt_reg     <= '0;
      we_reg      <= 1'b0;
      adr_reg     <= '0;
      wdata_reg   <= '0;
      w_op_reg    <= '0;
      m_rdata_reg <= '0;
      m_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            id_reg      <= win_id;
            last_id_reg <= win_id;
            cnt_reg     <= '0;
            we_reg      <= m_we[win_id];
            adr_reg     <= adr_arr[win_id];
            wdata_reg   <= wdata_arr[win_id];
            w_op_reg    <= w_op_arr[win_id];
          end
        end
        ACCESS: begin
          if (s_ready) begin
            m_rdata_reg <= s_rdata;
            m_err_reg   <= 1'b0;
          end else if (timeout_hit) begin
            m_rdata_reg <= '0;
            m_err_reg   <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_rdata = m_rdata_reg;
  assign m_err   = m_err_reg;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Bench for sys_bus_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level round-robin / latency model.
module tb_sys_bus_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int OW = 3;
  localparam int TO = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      m_request, m_abort, m_we;
  logic [N*AW-1:0]   m_adr;
  logic [N*DW-1:0]   m_wdata;
  logic [N*OW-1:0]   m_w_op;
  logic [N-1:0]      m_grant, m_rvalid;
  logic              m_err;
  logic [DW-1:0]     m_rdata;
  logic              s_request, s_we;
  logic [AW-1:0]     s_adr;
  logic [DW-1:0]     s_wdata;
  logic [OW-1:0]     s_w_op;
  logic [DW-1:0]     s_rdata;
  logic              s_ready;

  int tests = 0;
  int fails = 0;
  int model_last;
  logic [DW-1:0] exp_rdata;
  logic          exp_err;

  sys_bus_arbiter #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .W_OP_WIDTH(OW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_request(m_request), .m_abort(m_abort), .m_we(m_we), .m_adr(m_adr),
    .m_wdata(m_wdata), .m_w_op(m_w_op), .m_grant(m_grant), .m_rvalid(m_rvalid),
    .m_err(m_err), .m_rdata(m_rdata), .s_request(s_request), .s_we(s_we),
    .s_adr(s_adr), .s_wdata(s_wdata), .s_w_op(s_w_op), .s_rdata(s_rdata),
    .s_ready(s_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  function automatic int rr_pick(input logic [N-1:0] elig, input int last);
    for (int k = 1; k <= N; k++) begin
      if (elig[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic set_master(input int i, input logic we, input logic [AW-1:0] adr,
                            input logic [DW-1:0] wd, input logic [OW-1:0] op);
    m_we[i]            = we;
    m_adr[i*AW +: AW]  = adr;
    m_wdata[i*DW +: DW] = wd;
    m_w_op[i*OW +: OW] = op;
  endtask

  task automatic randomize_payload();
    for (int i = 0; i < N; i++)
      set_master(i, 1'($urandom), $urandom, $urandom, OW'($urandom));
  endtask

  // Starts at a negedge with the DUT idle; d = cycles s_ready stays low.
  task automatic run_txn(input string tag, input logic [N-1:0] req, input logic [N-1:0] abort,
                         input int d, input bit churn);
    int w, len;
    bit tmo;
    logic [N-1:0] oh;
    logic e_we;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_wd, rd;
    logic [OW-1:0] e_op;
    m_request = req;
    m_abort   = abort;
    s_ready   = 1'b0;
    w = rr_pick(req & ~abort, model_last);
    if (w < 0) begin
      @(negedge clk);
      tests++;
      if (m_grant !== '0 || m_rvalid !== '0 || s_request !== 1'b0) begin
        fails++;
        $display("FAIL %s no_eligible: grant=%b rvalid=%b s_request=%b, required all 0",
                 tag, m_grant, m_rvalid, s_request);
      end
      $display("[TB] txn %s: no eligible master", tag);
      return;
    end
    oh = '0;
    oh[w] = 1'b1;
    e_we  = m_we[w];
    e_adr = m_adr[w*AW +: AW];
    e_wd  = m_wdata[w*DW +: DW];
    e_op  = m_w_op[w*OW +: OW];
    model_last = w;
    tmo = (TO != 0) && (d >= TO);
    len = tmo ? TO : d + 1;
    rd  = '0;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      tests++;
      if (m_grant !== oh || s_request !== 1'b1 || m_rvalid !== '0) begin
        fails++;
        $display("FAIL %s access%0d ctrl: grant=%b s_request=%b rvalid=%b, required grant=%b s_request=1 rvalid=0",
                 tag, c, m_grant, s_request, m_rvalid, oh);
      end
      tests++;
      if (s_we !== e_we || s_adr !== e_adr || s_wdata !== e_wd || s_w_op !== e_op) begin
        fails++;
        $display("FAIL %s access%0d payload: we=%b adr=%h wdata=%h op=%h, required we=%b adr=%h wdata=%h op=%h",
                 tag, c, s_we, s_adr, s_wdata, s_w_op, e_we, e_adr, e_wd, e_op);
      end
      s_rdata = $urandom;
      s_ready = (c == d);
      if (c == d) rd = s_rdata;
      if (churn) begin
        m_request = N'($urandom);
        m_abort   = N'($urandom);
        randomize_payload();
      end
    end
    @(negedge clk);
    s_ready   = 1'b0;
    exp_rdata = tmo ? '0 : rd;
    exp_err   = tmo;
    tests++;
    if (m_rvalid !== oh || m_grant !== oh || s_request !== 1'b0) begin
      fails++;
      $display("FAIL %s resp ctrl: rvalid=%b grant=%b s_request=%b, required rvalid=%b grant=%b s_request=0",
               tag, m_rvalid, m_grant, s_request, oh, oh);
    end
    tests++;
    if (m_rdata !== exp_rdata || m_err !== exp_err) begin
      fails++;
      $display("FAIL %s resp data: rdata=%h err=%b, required rdata=%h err=%b",
               tag, m_rdata, m_err, exp_rdata, exp_err);
    end
    // Request held into the RESP->IDLE edge must not start a new access.
    m_request = req;
    m_abort   = abort;
    @(negedge clk);
    tests++;
    if (m_grant !== '0 || m_rvalid !== '0 || s_request !== 1'b0) begin
      fails++;
      $display("FAIL %s idle ctrl: grant=%b rvalid=%b s_request=%b, required all 0",
               tag, m_grant, m_rvalid, s_request);
    end
    tests++;
    if (m_rdata !== exp_rdata || m_err !== exp_err) begin
      fails++;
      $display("FAIL %s idle hold: rdata=%h err=%b, required rdata=%h err=%b",
               tag, m_rdata, m_err, exp_rdata, exp_err);
    end
    $display("[TB] txn %s: master=%0d access_cycles=%0d err=%0b rdata=%h", tag, w, len, tmo, exp_rdata);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_request = '0;
    m_abort = '0;
    s_ready = 1'b0;
    s_rdata = '0;
    randomize_payload();
    model_last = N - 1;
    exp_rdata = '0;
    exp_err = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (m_grant !== '0 || m_rvalid !== '0 || s_request !== 1'b0 || s_we !== 1'b0 ||
        s_adr !== '0 || s_wdata !== '0 || s_w_op !== '0 || m_rdata !== '0 || m_err !== 1'b0) begin
      fails++;
      $display("FAIL reset outputs: grant=%b rvalid=%b s_request=%b adr=%h rdata=%h err=%b, required all 0",
               m_grant, m_rvalid, s_request, s_adr, m_rdata, m_err);
    end
    rst = 1'b0;
    $display("[TB] txn reset: released");
  endtask

  task automatic test_single();
    set_master(0, 1'b0, 32'h0000_0100, 32'h0, 3'd0);
    run_txn("single_m0", 2'b01, 2'b00, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      randomize_payload();
      run_txn("alternate", 2'b11, 2'b00, 0, 1'b0);
    end
  endtask

  task automatic test_abort();
    randomize_payload();
    run_txn("abort_m0", 2'b11, 2'b01, 0, 1'b0);
    run_txn("abort_m0_again", 2'b11, 2'b01, 1, 1'b0);
    run_txn("abort_dropped", 2'b11, 2'b00, 0, 1'b0);
    run_txn("all_aborted", 2'b11, 2'b11, 0, 1'b0);
  endtask

  task automatic test_timeout();
    randomize_payload();
    run_txn("timeout", 2'b01, 2'b00, 20, 1'b0);
    run_txn("retry", 2'b01, 2'b00, 0, 1'b0);
    run_txn("ready_on_last", 2'b10, 2'b00, TO - 1, 1'b0);
    run_txn("timeout_exact", 2'b10, 2'b00, TO, 1'b0);
  endtask

  task automatic test_reset_mid();
    set_master(0, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 3'd2);
    m_request = 2'b01;
    m_abort = 2'b00;
    s_ready = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (s_request !== 1'b1 || s_wdata !== 32'hDEAD_BEEF || m_grant !== 2'b01) begin
      fails++;
      $display("FAIL reset_mid pre: s_request=%b wdata=%h grant=%b, required 1/deadbeef/01",
               s_request, s_wdata, m_grant);
    end
    m_request = 2'b11;
    #1 rst = 1'b1;
    #1;
    tests++;
    if (s_request !== 1'b0 || m_grant !== '0 || m_rvalid !== '0 || m_rdata !== '0 || m_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid async: s_request=%b grant=%b rvalid=%b rdata=%h err=%b, required all 0",
               s_request, m_grant, m_rvalid, m_rdata, m_err);
    end
    @(negedge clk);
    rst = 1'b0;
    model_last = N - 1;
    exp_rdata = '0;
    exp_err = 1'b0;
    $display("[TB] txn reset_mid: reset during access");
    run_txn("none_after_rst", 2'b00, 2'b00, 0, 1'b0);
    run_txn("after_rst", 2'b11, 2'b00, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [N-1:0] req, ab;
    for (int t = 0; t < 60; t++) begin
      randomize_payload();
      req = N'($urandom);
      ab  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      run_txn("random", req, ab, $urandom_range(0, TO + 2), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
